fpga_serial_tx: RTL

Parametrised serial transmitter for the FPGA-to-FPGA link, combining control FSM and datapath in one block. It captures a DATA_W-bit word on `start` and sends it one bit per four-phase `txValid`/`ack` handshake. It optionally appends an even-parity bit, and bounds every handshake wait with a timeout. On timeout it restarts the frame up to MAX_RETRY times. It sits between local user logic and the inter-FPGA pins, with the peer receiver driving `ack`.

---
 rtl/fpga_serial_tx.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/fpga_serial_tx.sv
// Serial transmitter for the FPGA-to-FPGA link.
// Sends a DATA_W-bit word (plus optional even parity) one bit per four-phase
// txValid/ack handshake. Every handshake wait is bounded by a timeout, and the
// frame is restarted up to MAX_RETRY times before error is pulsed.
module fpga_serial_tx #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned PARITY_EN = 0,
  parameter int unsigned LSB_FIRST = 1,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  input  logic              ack,
  output logic              busy,
  output logic              txData,
  output logic              txValid,
  output logic              txLast,
  output logic              done,
  output logic              error
);

  localparam int unsigned FRAME_W = DATA_W + PARITY_EN;
  localparam int unsigned CNT_W   = $clog2(FRAME_W);
  localparam int unsigned TIM_W   = $clog2(TIMEOUT);
  localparam int unsigned RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);
  localparam logic [TIM_W-1:0] TIM_LAST = TIM_W'(TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    REL,
    DONE,
    RETRY,
    FAIL
  } stateT;

  stateT              state;
  logic [DATA_W-1:0]  hold;
  logic [FRAME_W-1:0] shreg;
  logic [CNT_W-1:0]   bitCnt;
  logic [TIM_W-1:0]   timer;
  logic [RTY_W-1:0]   retryCnt;
  logic               ackMeta;
  logic               ackS;
  logic [FRAME_W-1:0] loadFrame;
  logic [FRAME_W-1:0] retryFrame;

  // Bit 0 of the frame is always the next bit on the wire; parity sits at the top.
  function automatic logic [FRAME_W-1:0] buildFrame(input logic [DATA_W-1:0] d);
    logic [FRAME_W-1:0] f;
    f = '0;
    f[DATA_W-1:0] = (LSB_FIRST != 0) ? d : {<<{d}};
    if (PARITY_EN != 0) f[FRAME_W-1] = ^d;
    return f;
  endfunction

  // Frame images for a fresh accept and for a retry restart.
  always_comb begin
    loadFrame  = buildFrame(data);
    retryFrame = buildFrame(hold);
  end

  // Control FSM, datapath, ack synchroniser and registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= IDLE;
      hold     <= '0;
      shreg    <= '0;
      bitCnt   <= '0;
      timer    <= '0;
      retryCnt <= '0;
      ackMeta  <= 1'b0;
      ackS     <= 1'b0;
      busy     <= 1'b0;
      txData   <= 1'b0;
      txValid  <= 1'b0;
      txLast   <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      ackMeta <= ack;
      ackS    <= ackMeta;
      case (state)
        IDLE: begin
          if (start) begin
            hold     <= data;
            shreg    <= loadFrame;
            bitCnt   <= '0;
            retryCnt <= '0;
            timer    <= '0;
            busy     <= 1'b1;
            txValid  <= 1'b1;
            txData   <= loadFrame[0];
            txLast   <= 1'b0;
            state    <= REQ;
          end
        end
        REQ: begin
          if (ackS) begin
            txValid <= 1'b0;
            txLast  <= 1'b0;
            timer   <= '0;
            state   <= REL;
          end else if (timer == TIM_LAST) begin
            txValid <= 1'b0;
            txLast  <= 1'b0;
            timer   <= '0;
            if (retryCnt < RTY_MAX) begin
              retryCnt <= retryCnt + 1'b1;
              shreg    <= retryFrame;
              bitCnt   <= '0;
              state    <= RETRY;
            end else begin
              error <= 1'b1;
              state <= FAIL;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        REL: begin
          if (!ackS) begin
            timer <= '0;
            if (bitCnt == LAST_BIT) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              shreg   <= shreg >> 1;
              bitCnt  <= bitCnt + 1'b1;
              txData  <= shreg[1];
              txLast  <= (bitCnt + 1'b1 == LAST_BIT);
              txValid <= 1'b1;
              state   <= REQ;
            end
          end else if (timer == TIM_LAST) begin
            timer <= '0;
            if (retryCnt < RTY_MAX) begin
              retryCnt <= retryCnt + 1'b1;
              shreg    <= retryFrame;
              bitCnt   <= '0;
              state    <= RETRY;
            end else begin
              error <= 1'b1;
              state <= FAIL;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RETRY: begin
          if (!ackS) begin
            timer   <= '0;
            txValid <= 1'b1;
            txData  <= shreg[0];
            txLast  <= 1'b0;
            state   <= REQ;
          end else if (timer == TIM_LAST) begin
            timer <= '0;
            error <= 1'b1;
            state <= FAIL;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        FAIL: begin
          error <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
